// File: rtl/arythcrypt_pkg.sv
// rtl/arythcrypt_pkg.sv - shared op/state encodings and Control field layout for the arythcrypt cores
package arythcrypt_pkg;

  typedef enum logic [1:0] {
    OP_XOR    = 2'b00,
    OP_ADD    = 2'b01,
    OP_SUB    = 2'b10,
    OP_ROTXOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int CTRL_OP_LSB  = 0;
  localparam int CTRL_OP_MSB  = 1;
  localparam int CTRL_RND_LSB = 2;
  localparam int CTRL_RND_MSB = 3;

  localparam logic [7:0] KEY_STEP_DEF = 8'h01;

endpackage

// File: rtl/arythcrypt_inv_round.sv
// rtl/arythcrypt_inv_round.sv - one combinational inverse cipher round
// ARYTHCRYPT_DEC_ROTXOR_EN builds the right-rotator; otherwise op 11 decodes as XOR.
module arythcrypt_inv_round
  import arythcrypt_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [7:0] key_i,
  input  logic [1:0] op_i,
  output logic [7:0] data_o
);

`ifdef ARYTHCRYPT_DEC_ROTXOR_EN
  logic [7:0]  mix;
  logic [15:0] dbl;

  always_comb begin
    mix = data_i ^ key_i;
    dbl = {mix, mix} >> key_i[2:0];
  end
`endif

  always_comb begin
    data_o = data_i ^ key_i;
    case (op_e'(op_i))
      OP_ADD:    data_o = data_i - key_i;
      OP_SUB:    data_o = data_i + key_i;
`ifdef ARYTHCRYPT_DEC_ROTXOR_EN
      OP_ROTXOR: data_o = dbl[7:0];
`endif
      default:   data_o = data_i ^ key_i;
    endcase
  end

endmodule

// File: rtl/erythcrypt_decrypt.sv
// rtl/erythcrypt_decrypt.sv - iterative decryption core, one inverse round per clock
// Option: ARYTHCRYPT_DEC_ROTXOR_EN enables the ROTXOR inverse in arythcrypt_inv_round.
module erythcrypt_decrypt
  import arythcrypt_pkg::*;
#(
  parameter logic [7:0] KEY_STEP = KEY_STEP_DEF
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  input  logic [3:0] Control,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] OUTPUT
);

  state_e     state_q;
  logic [7:0] data_q;
  logic [7:0] key_q;
  logic [1:0] op_q;
  logic [1:0] cnt_q;
  logic [7:0] out_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] rkey_d;
  logic [7:0] data_d;

  // Rounds run last-to-first, so the round key is derived from the down-counter.
  always_comb begin
    rkey_d = key_q + 8'({6'b0, cnt_q} * KEY_STEP);
  end

  arythcrypt_inv_round u_inv_round (
    .data_i (data_q),
    .key_i  (rkey_d),
    .op_i   (op_q),
    .data_o (data_d)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      key_q   <= 8'h00;
      op_q    <= 2'b00;
      cnt_q   <= 2'b00;
      out_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            data_q  <= I1;
            key_q   <= I2;
            op_q    <= Control[CTRL_OP_MSB:CTRL_OP_LSB];
            cnt_q   <= Control[CTRL_RND_MSB:CTRL_RND_LSB];
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          data_q <= data_d;
          cnt_q  <= cnt_q - 2'd1;
          if (cnt_q == 2'd0) begin
            out_q   <= data_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign OUTPUT = out_q;

endmodule

// File: tb/tb_erythcrypt_decrypt.sv
// tb/tb_erythcrypt_decrypt.sv - self-checking bench for erythcrypt_decrypt (honours ARYTHCRYPT_DEC_ROTXOR_EN)
module tb_erythcrypt_decrypt;

  localparam logic [7:0] KS = 8'h01;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [7:0] I1;
  logic [7:0] I2;
  logic [3:0] Control;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic [7:0] OUTPUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  erythcrypt_decrypt #(.KEY_STEP(KS)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .I1      (I1),
    .I2      (I2),
    .Control (Control),
    .Start   (Start),
    .Busy    (Busy),
    .Done    (Done),
    .OUTPUT  (OUTPUT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forward cipher written from the round rules; decryption must undo it.
  function automatic logic [7:0] encrypt(input logic [7:0] p, input logic [7:0] k, input logic [3:0] ctrl);
    int x, kr, s, n, op;
    x  = int'(p);
    n  = int'(ctrl[3:2]) + 1;
    op = int'(ctrl[1:0]);
`ifndef ARYTHCRYPT_DEC_ROTXOR_EN
    if (op == 3) op = 0;
`endif
    for (int r = 0; r < n; r++) begin
      kr = (int'(k) + r * int'(KS)) % 256;
      s  = kr % 8;
      case (op)
        0: x = x ^ kr;
        1: x = (x + kr) % 256;
        2: x = (x - kr + 256) % 256;
        default: x = ((((x << s) | (x >> (8 - s))) & 255) ^ kr);
      endcase
    end
    return 8'(x);
  endfunction

  task automatic run_job(input logic [7:0] c, input logic [7:0] k, input logic [3:0] ctrl,
                         output logic [7:0] res, output int lat, output int bcnt);
    @(negedge CLK);
    I1 = c; I2 = k; Control = ctrl; Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    I1 = 8'($urandom); I2 = 8'($urandom); Control = 4'($urandom);
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (Busy) bcnt++;
      if (Done) begin
        lat = i;
        break;
      end
    end
    res = OUTPUT;
  endtask

  task automatic job_check(input string tag, input logic [7:0] c, input logic [7:0] k,
                           input logic [3:0] ctrl, input logic [7:0] exp);
    logic [7:0] res;
    int lat, bcnt, n;
    n = int'(ctrl[3:2]) + 1;
    run_job(c, k, ctrl, res, lat, bcnt);
    check({tag, "_out"}, 32'(res), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(n + 1));
    check({tag, "_busy"}, 32'(bcnt), 32'(n));
  endtask

  initial begin
    logic [7:0] p, k, c;
    logic [3:0] ctrl;
    int lat, bcnt, dones;

    Reset = 1'b1; Start = 1'b0; I1 = 8'h00; I2 = 8'h00; Control = 4'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_out", 32'(OUTPUT), 32'h00);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    Reset = 1'b0;

    job_check("xor1", 8'h5A, 8'h3C, 4'b0000, 8'h66);
    @(negedge CLK);
    check("done_pulse", 32'(Done), 32'h0);
    job_check("add2", 8'h1B, 8'h05, 4'b0101, 8'h10);
    job_check("sub1_wrap", 8'hFD, 8'h05, 4'b0010, 8'h02);
`ifdef ARYTHCRYPT_DEC_ROTXOR_EN
    job_check("rotxor1", 8'h0F, 8'h03, 4'b0011, 8'h81);
`else
    job_check("rotxor1", 8'h0F, 8'h03, 4'b0011, 8'h0C);
`endif
    job_check("xor4_keywrap", 8'h00, 8'hFF, 4'b1100, 8'hFC);

    for (int i = 0; i < 24; i++) begin
      p = 8'($urandom); k = 8'($urandom); ctrl = 4'($urandom);
      c = encrypt(p, k, ctrl);
      job_check($sformatf("rand%0d", i), c, k, ctrl, p);
    end

    // Reset during the second RUN cycle aborts the job.
    job_check("pre_abort", 8'h00, 8'hFF, 4'b1100, 8'hFC);
    @(negedge CLK);
    I1 = 8'h12; I2 = 8'h34; Control = 4'b1101; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1 Reset = 1'b0;
    @(negedge CLK);
    check("abort_out", 32'(OUTPUT), 32'h00);
    check("abort_busy", 32'(Busy), 32'h0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      @(negedge CLK);
    end
    check("abort_no_done", 32'(dones), 32'h0);

    // Start held high through RUN and DONE: only re-accepted from IDLE.
    I1 = 8'h1B; I2 = 8'h05; Control = 4'b0101; Start = 1'b1;
    @(posedge CLK);
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (Busy) bcnt++;
      if (Done) begin
        lat = i;
        break;
      end
    end
    check("held_lat", 32'(lat), 32'd3);
    check("held_busy", 32'(bcnt), 32'd2);
    check("held_out", 32'(OUTPUT), 32'h10);
    @(negedge CLK);
    check("held_idle_busy", 32'(Busy), 32'h0);
    @(negedge CLK);
    check("held_reaccept", 32'(Busy), 32'h1);
    Start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (Done) begin
        lat = i;
        break;
      end
    end
    check("held_second_done", 32'(lat > 0), 32'h1);
    check("held_second_out", 32'(OUTPUT), 32'h10);

    // Reset and Start together: reset wins.
    @(negedge CLK);
    Reset = 1'b1; Start = 1'b1;
    @(posedge CLK);
    #1 Reset = 1'b0; Start = 1'b0;
    @(negedge CLK);
    check("rst_start_busy", 32'(Busy), 32'h0);
    check("rst_start_out", 32'(OUTPUT), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
